// File: rtl/e203_exu_flush_arb.sv
// N-channel fixed-priority pipeline-flush arbiter: locks the grant until the IFU acks,
// honours halt, flags dropped requests and counts flushes. Optional PC adder: E203_FLUSH_ARB_PCADD_EN.
module e203_exu_flush_arb #(
  parameter int NCH   = 2,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16,
  localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      req_i,
  input  logic [NCH*PC_W-1:0] op1_i,
  input  logic [NCH*PC_W-1:0] op2_i,
  output logic [NCH-1:0]      ack_o,
  input  logic                halt_i,
  output logic                pipe_flush_req_o,
  output logic [PC_W-1:0]     pipe_flush_add_op1_o,
  output logic [PC_W-1:0]     pipe_flush_add_op2_o,
`ifdef E203_FLUSH_ARB_PCADD_EN
  output logic [PC_W-1:0]     pipe_flush_pc_o,
`endif
  input  logic                pipe_flush_ack_i,
  output logic [IDW-1:0]      grant_id_o,
  output logic                flush_pulse_o,
  output logic [CNT_W-1:0]    flush_cnt_o,
  input  logic                cnt_clr_i,
  output logic                err_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   lock_q;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   sel;
  logic             any_req;
  logic             flush_req;
  logic             op_valid;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  // Lowest index wins: scan downward so the last assignment is the highest priority.
  always_comb begin
    win = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_i[k]) win = IDW'(k);
    end
  end

  assign any_req = |req_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    sel       = win;
    flush_req = 1'b0;
    ack_o     = '0;
    case (state_q)
      IDLE: begin
        sel       = win;
        flush_req = any_req & ~halt_i;
        if (flush_req & ~pipe_flush_ack_i) state_d = LOCK;
      end
      LOCK: begin
        // Halt is ignored here: an in-flight flush always completes.
        sel       = lock_q;
        flush_req = req_i[lock_q];
        if (~req_i[lock_q] | pipe_flush_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) flush_req = 1'b0;
    if (flush_req & pipe_flush_ack_i) ack_o[sel] = 1'b1;
  end

  assign op_valid             = (state_q == LOCK) | any_req;
  assign pipe_flush_req_o     = flush_req;
  assign flush_pulse_o        = flush_req & pipe_flush_ack_i;
  assign grant_id_o           = op_valid ? sel : '0;
  assign pipe_flush_add_op1_o = op_valid ? op1_i[sel*PC_W +: PC_W] : '0;
  assign pipe_flush_add_op2_o = op_valid ? op2_i[sel*PC_W +: PC_W] : '0;

`ifdef E203_FLUSH_ARB_PCADD_EN
  assign pipe_flush_pc_o = pipe_flush_add_op1_o + pipe_flush_add_op2_o;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == LOCK)) lock_q <= win;
      if (cnt_clr_i)                              cnt_q <= '0;
      else if (flush_pulse_o && (cnt_q != '1))    cnt_q <= cnt_q + 1'b1;
      if ((state_q == LOCK) && !req_i[lock_q])    err_q <= 1'b1;
    end
  end

  assign flush_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Directed testbench for e203_exu_flush_arb with NCH=3, CNT_W=2.
module tb_e203_exu_flush_arb;
  localparam int NCH = 3, PC_W = 32, CNT_W = 2, IDW = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      req;
  logic [NCH*PC_W-1:0] op1, op2;
  logic [NCH-1:0]      ack_o;
  logic                halt;
  logic                flush_req_o;
  logic [PC_W-1:0]     add_op1_o, add_op2_o;
`ifdef E203_FLUSH_ARB_PCADD_EN
  logic [PC_W-1:0]     pc_o;
`endif
  logic                flush_ack;
  logic [IDW-1:0]      grant_o;
  logic                pulse_o;
  logic [CNT_W-1:0]    cnt_o;
  logic                cnt_clr;
  logic                err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  e203_exu_flush_arb #(.NCH(NCH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_i(req), .op1_i(op1), .op2_i(op2), .ack_o(ack_o),
    .halt_i(halt), .pipe_flush_req_o(flush_req_o),
    .pipe_flush_add_op1_o(add_op1_o), .pipe_flush_add_op2_o(add_op2_o),
`ifdef E203_FLUSH_ARB_PCADD_EN
    .pipe_flush_pc_o(pc_o),
`endif
    .pipe_flush_ack_i(flush_ack), .grant_id_o(grant_o), .flush_pulse_o(pulse_o),
    .flush_cnt_o(cnt_o), .cnt_clr_i(cnt_clr), .err_o(err_o)
  );

  // Advance one clock edge; inputs change 1 ns after it, outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 3'b001; flush_ack = 1'b1; halt = 1'b0; cnt_clr = 1'b0;
    settle();
    checks++; if (flush_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", flush_req_o); end
    checks++; if (ack_o !== 3'b000) begin errors++; $display("FAIL rst_ack got %b exp 000", ack_o); end
    tick();
    checks++; if (cnt_o !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_o); end
    req = 3'b000; flush_ack = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_empty();
    req = 3'b000; flush_ack = 1'b1;
    settle();
    checks++; if (flush_req_o !== 1'b0 || ack_o !== 3'b000) begin errors++; $display("FAIL empty_req got %b/%b exp 0/000", flush_req_o, ack_o); end
    checks++; if (grant_o !== 2'd0 || add_op1_o !== 32'h0 || add_op2_o !== 32'h0) begin
      errors++; $display("FAIL empty_ops got %0d %h %h exp 0 0 0", grant_o, add_op1_o, add_op2_o); end
    flush_ack = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 3'b010; flush_ack = 1'b1;
    settle();
    checks++; if (ack_o !== 3'b010) begin errors++; $display("FAIL single_ack got %b exp 010", ack_o); end
    checks++; if (flush_req_o !== 1'b1 || pulse_o !== 1'b1 || grant_o !== 2'd1) begin
      errors++; $display("FAIL single_req got %b %b %0d exp 1 1 1", flush_req_o, pulse_o, grant_o); end
    checks++; if (add_op1_o !== 32'h8000_0000 || add_op2_o !== 32'h10) begin
      errors++; $display("FAIL single_ops got %h %h exp 80000000 10", add_op1_o, add_op2_o); end
`ifdef E203_FLUSH_ARB_PCADD_EN
    checks++; if (pc_o !== 32'h8000_0010) begin errors++; $display("FAIL single_pc got %h exp 80000010", pc_o); end
`endif
    tick();
    req = 3'b000; flush_ack = 1'b0;
    settle();
    checks++; if (cnt_o !== 2'd1) begin errors++; $display("FAIL single_cnt got %0d exp 1", cnt_o); end
  endtask

  task automatic test_lock();
    req = 3'b100; flush_ack = 1'b0;
    settle();
    checks++; if (flush_req_o !== 1'b1 || grant_o !== 2'd2 || ack_o !== 3'b000) begin
      errors++; $display("FAIL lock_first got %b %0d %b exp 1 2 000", flush_req_o, grant_o, ack_o); end
    tick(); tick();
    req = 3'b101;
    settle();
    checks++; if (grant_o !== 2'd2 || flush_req_o !== 1'b1) begin
      errors++; $display("FAIL lock_hold got %0d %b exp 2 1", grant_o, flush_req_o); end
    checks++; if (add_op1_o !== 32'h0000_2000) begin errors++; $display("FAIL lock_op1 got %h exp 00002000", add_op1_o); end
    tick();
    flush_ack = 1'b1;
    settle();
    checks++; if (ack_o !== 3'b100) begin errors++; $display("FAIL lock_ack got %b exp 100", ack_o); end
    tick();
    req = 3'b001; flush_ack = 1'b0;
    settle();
    checks++; if (grant_o !== 2'd0 || flush_req_o !== 1'b1) begin
      errors++; $display("FAIL lock_next got %0d %b exp 0 1", grant_o, flush_req_o); end
    checks++; if (cnt_o !== 2'd2) begin errors++; $display("FAIL lock_cnt got %0d exp 2", cnt_o); end
    tick();
    flush_ack = 1'b1;
    settle();
    checks++; if (ack_o !== 3'b001) begin errors++; $display("FAIL lock_ack0 got %b exp 001", ack_o); end
    tick();
    req = 3'b000; flush_ack = 1'b0;
    tick();
  endtask

  task automatic test_halt();
    halt = 1'b1; req = 3'b001; flush_ack = 1'b1;
    settle();
    checks++; if (flush_req_o !== 1'b0 || ack_o !== 3'b000) begin
      errors++; $display("FAIL halt_idle got %b %b exp 0 000", flush_req_o, ack_o); end
    tick();
    halt = 1'b0; flush_ack = 1'b0;
    tick();
    halt = 1'b1;
    settle();
    checks++; if (flush_req_o !== 1'b1) begin errors++; $display("FAIL halt_lock_req got %b exp 1", flush_req_o); end
    flush_ack = 1'b1;
    settle();
    checks++; if (ack_o !== 3'b001) begin errors++; $display("FAIL halt_lock_ack got %b exp 001", ack_o); end
    tick();
    req = 3'b000; flush_ack = 1'b0; halt = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    req = 3'b010; flush_ack = 1'b0;
    tick();
    req = 3'b000;
    settle();
    checks++; if (flush_req_o !== 1'b0) begin errors++; $display("FAIL drop_req got %b exp 0", flush_req_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL drop_err_early got %b exp 0", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL drop_err got %b exp 1", err_o); end
    req = 3'b001; flush_ack = 1'b1;
    settle();
    checks++; if (ack_o !== 3'b001) begin errors++; $display("FAIL drop_idle_ack got %b exp 001", ack_o); end
    tick();
    req = 3'b000; flush_ack = 1'b0;
    tick(); tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b exp 1", err_o); end
  endtask

  task automatic test_counter();
    logic [CNT_W-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    checks++; if (cnt_o !== 2'd0) begin errors++; $display("FAIL cnt_clr got %0d exp 0", cnt_o); end
    req = 3'b001; flush_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (cnt_o !== exp_cnt[i]) begin errors++; $display("FAIL cnt_step%0d got %0d exp %0d", i, cnt_o, exp_cnt[i]); end
    end
    cnt_clr = 1'b1;
    settle();
    checks++; if (pulse_o !== 1'b1) begin errors++; $display("FAIL cnt_clr_pulse got %b exp 1", pulse_o); end
    tick();
    cnt_clr = 1'b0; req = 3'b000; flush_ack = 1'b0;
    checks++; if (cnt_o !== 2'd0) begin errors++; $display("FAIL cnt_clr_pri got %0d exp 0", cnt_o); end
    tick();
  endtask

  task automatic test_reset_in_lock();
    req = 3'b001; flush_ack = 1'b1;
    tick();
    req = 3'b100; flush_ack = 1'b0;
    tick();
    req = 3'b101; rst = 1'b1;
    settle();
    checks++; if (flush_req_o !== 1'b0 || ack_o !== 3'b000) begin
      errors++; $display("FAIL rstlock_out got %b %b exp 0 000", flush_req_o, ack_o); end
    tick();
    rst = 1'b0;
    checks++; if (cnt_o !== 2'd0 || err_o !== 1'b0) begin
      errors++; $display("FAIL rstlock_regs got %0d %b exp 0 0", cnt_o, err_o); end
    flush_ack = 1'b1;
    settle();
    checks++; if (grant_o !== 2'd0 || ack_o !== 3'b001) begin
      errors++; $display("FAIL rstlock_regrant got %0d %b exp 0 001", grant_o, ack_o); end
    tick();
    req = 3'b000; flush_ack = 1'b0;
  endtask

  initial begin
    op1 = {32'h0000_2000, 32'h8000_0000, 32'h0000_1000};
    op2 = {32'h0000_0020, 32'h0000_0010, 32'h0000_0004};
    test_reset();
    test_idle_empty();
    test_single();
    test_lock();
    test_halt();
    test_drop();
    test_counter();
    test_reset_in_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
